signal_change_capture: RTL
==========================

Name: signal_change_capture

Overview:
- Upstream feeder for the per-signal DPI probe.
- Watches one WIDTH-bit design signal and detects value changes.
- Stamps each change with a free-running cycle count and buffers events in a DEPTH-entry FIFO.
- Drains events through a valid/ready port. The probe samples that port every clock, so the simulator sees a change log instead of a per-cycle dump.

Parameters:
- WIDTH, 32, width of the monitored signal and of out_value.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_WIDTH, 32, cycle-counter and timestamp width.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  capture enable.
- sig_in  in  WIDTH  monitored signal.
- out_valid  out  1  head event available.
- out_ready  in  1  consumer accepts head event.
- out_value  out  WIDTH  event value.
- out_time  out  TS_WIDTH  event timestamp.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  count of dropped events; saturating.
- overflow  out  1  sticky flag; set on the first drop.

Behaviour:
- Reset (reset=0, asynchronous): all of the following are cleared.
  - Outputs: out_valid=0, out_value=0, out_time=0, level=0, drop_count=0, overflow=0.
  - Internal state: cycle counter=0, prev=0, armed=1, read/write pointers=0.
  - Asserting reset mid-operation discards all buffered events immediately.
- Cycle counter:
  - Increments by 1 every clock while reset=1, independent of enable.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
  - An event captured at edge t carries the counter value present before edge t: 0 for the first edge after reset release.
- Capture condition, evaluated each edge: push = enable & (armed | (sig_in != prev)).
  - On enable=1: prev <= sig_in and armed <= 0.
  - On enable=0: prev holds. armed <= 1, so the first enabled cycle afterwards always captures the current value.
  - After reset, armed=1, so the first enabled cycle after reset always captures.
- FIFO:
  - Push writes {sig_in, counter} at the write pointer.
  - Pop = out_valid & out_ready.
  - Pointers carry one extra wrap bit. level = wr - rd, range 0..DEPTH.
- Latency and bypass:
  - No combinational bypass.
  - An event pushed into an empty FIFO at edge t gives out_valid=1 after edge t.
  - Minimum latency from sig_in change to out_valid is 1 cycle.
- Full (level==DEPTH):
  - Push without pop: the event is dropped and the FIFO is unchanged.
  - On each drop, drop_count += 1, saturating at 16'hFFFF, and overflow <= 1. overflow clears only on reset.
- Full with simultaneous push and pop: both take effect and level stays DEPTH. No drop.
- Empty with simultaneous push and pop: impossible, because out_valid=0.
- Output holding:
  - While out_valid=1, out_value/out_time show the head entry. They stay stable until popped, regardless of sig_in.
  - While out_valid=0, out_value/out_time hold the last popped entry, or 0 if nothing has been popped since reset. The always-sampling probe therefore never sees garbage.
- out_ready is ignored while out_valid=0.
- Changes that toggle back within one cycle are still captured, because sampling occurs every edge.
- Implementation: all outputs are registered or derived only from registers. No combinational input-to-output path except through state.

Test Plan:
1. Reset release; enable=1, sig_in=32'h5, out_ready=1, held 5 cycles -> one event {5, time 0}; out_valid high for exactly 1 cycle; afterwards out_value stays 5, level=0.
2. sig_in sequence 1,1,2,2,2,3 with enable=1, out_ready=0 -> level=3; entries drained in order with timestamps 0,2,5; no extra events.
3. DEPTH=8, out_ready=0, sig_in changes every cycle for 11 cycles -> level=8, drop_count=3, overflow=1; drained values are the first 8 with consecutive timestamps.
4. FIFO full, out_ready=1 and a new change in the same cycle -> level stays 8, drop_count unchanged, new event appears at the tail.
5. enable=0 for 4 cycles while sig_in changes, then enable=1 with sig_in unchanged -> exactly one event with the current value and the enable-cycle timestamp.
6. Assert reset=0 asynchronously with level=5 mid-drain -> out_valid, level and drop_count go to 0 without a clock edge; the counter restarts at 0 after release.

Source files
------------

// File: rtl/signal_change_capture.sv
// Change-only capture front end: stamps each value change of a monitored signal
// with a free-running cycle count and buffers it in a small FIFO for the probe.
module signal_change_capture #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         sig_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_value,
  output logic [TS_WIDTH-1:0]      out_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_WIDTH-1:0] cntQ, cntD;
  logic [WIDTH-1:0]    prevQ, prevD;
  logic                armedQ, armedD;
  logic [AW:0]         wrQ, wrD, rdQ, rdD;
  logic [WIDTH-1:0]    outValQ, outValD;
  logic [TS_WIDTH-1:0] outTimeQ, outTimeD;
  logic [15:0]         dropQ, dropD;
  logic                ovfQ, ovfD;

  logic [WIDTH-1:0]    valMem [DEPTH];
  logic [TS_WIDTH-1:0] tsMem  [DEPTH];

  logic [AW:0] levelW;
  logic        empty, full, pop, pushReq, doPush, drop;

  assign levelW  = wrQ - rdQ;
  assign empty   = (wrQ == rdQ);
  assign full    = (levelW == (AW+1)'(DEPTH));
  assign pop     = !empty && out_ready;
  assign pushReq = enable && (armedQ || (sig_in != prevQ));
  assign doPush  = pushReq && (!full || pop);
  assign drop    = pushReq && full && !pop;

  always_comb begin
    cntD     = cntQ + TS_WIDTH'(1);
    prevD    = prevQ;
    armedD   = 1'b1;
    wrD      = wrQ + {{AW{1'b0}}, doPush};
    rdD      = rdQ + {{AW{1'b0}}, pop};
    outValD  = outValQ;
    outTimeD = outTimeQ;
    dropD    = dropQ;
    ovfD     = ovfQ;

    if (enable) begin
      prevD  = sig_in;
      armedD = 1'b0;
    end

    if (drop) begin
      ovfD = 1'b1;
      if (dropQ != 16'hFFFF) dropD = dropQ + 16'd1;
    end

    // Preload the output register with the post-edge head; when the new head
    // is the entry being written this edge, memory does not hold it yet.
    if (wrD != rdD) begin
      if (rdD == wrQ) begin
        outValD  = sig_in;
        outTimeD = cntQ;
      end else begin
        outValD  = valMem[rdD[AW-1:0]];
        outTimeD = tsMem[rdD[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cntQ     <= '0;
      prevQ    <= '0;
      armedQ   <= 1'b1;
      wrQ      <= '0;
      rdQ      <= '0;
      outValQ  <= '0;
      outTimeQ <= '0;
      dropQ    <= '0;
      ovfQ     <= 1'b0;
    end else begin
      cntQ     <= cntD;
      prevQ    <= prevD;
      armedQ   <= armedD;
      wrQ      <= wrD;
      rdQ      <= rdD;
      outValQ  <= outValD;
      outTimeQ <= outTimeD;
      dropQ    <= dropD;
      ovfQ     <= ovfD;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) begin
      valMem[wrQ[AW-1:0]] <= sig_in;
      tsMem[wrQ[AW-1:0]]  <= cntQ;
    end
  end

  assign out_valid  = !empty;
  assign out_value  = outValQ;
  assign out_time   = outTimeQ;
  assign level      = levelW;
  assign drop_count = dropQ;
  assign overflow   = ovfQ;

endmodule
